// File: rtl/triangle_classifier.sv
// Sequential triangle classifier: three compare-and-swap sort steps, then a registered
// classification. Optional right-angle detection is enabled with `define TRIANGLE_RIGHT_EN.
module triangle_classifier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             IS_TRI,
  output logic             IS_EQU,
  output logic             IS_ISO,
  output logic             IS_RIGHT,
  output logic [WIDTH-1:0] MAX_SIDE,
  output logic [CNT_W-1:0] TRI_CNT
);

  typedef enum logic [2:0] {IDLE, SORT1, SORT2, SORT3, CALC, OUT} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
  logic             tri_q, equ_q, iso_q, right_q;
  logic             tri_d, equ_d, iso_d, right_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_fire, out_fire;
  logic [WIDTH:0]   sum;
  logic             tri_c, equ_c, iso_c, right_c;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire) state_d = SORT1;
      SORT1:   state_d = SORT2;
      SORT2:   state_d = SORT3;
      SORT3:   state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    IN_READY  = (state_q == IDLE);
    OUT_VALID = (state_q == OUT);
  end

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = OUT_VALID & OUT_READY;

  // Sorting network applied in place, one compare-and-swap per cycle
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    case (state_q)
      IDLE: if (in_fire) begin
        x_d = A;
        y_d = B;
        z_d = C;
      end
      SORT1: if (x_q > y_q) begin
        x_d = y_q;
        y_d = x_q;
      end
      SORT2: if (y_q > z_q) begin
        y_d = z_q;
        z_d = y_q;
      end
      SORT3: if (x_q > y_q) begin
        x_d = y_q;
        y_d = x_q;
      end
      default: ;
    endcase
  end

  // Sides are sorted here, so a single Z < X+Y test covers all three inequalities
  assign sum   = {1'b0, x_q} + {1'b0, y_q};
  assign tri_c = ({1'b0, z_q} < sum);
  assign equ_c = tri_c & (x_q == z_q);
  assign iso_c = tri_c & ((x_q == y_q) | (y_q == z_q));

`ifdef TRIANGLE_RIGHT_EN
  localparam int PW = 2*WIDTH + 1;
  logic [PW-1:0] xx, yy, zz;
  assign xx      = PW'(x_q) * PW'(x_q);
  assign yy      = PW'(y_q) * PW'(y_q);
  assign zz      = PW'(z_q) * PW'(z_q);
  assign right_c = tri_c & ((xx + yy) == zz);
`else
  assign right_c = 1'b0;
`endif

  always_comb begin
    tri_d   = tri_q;
    equ_d   = equ_q;
    iso_d   = iso_q;
    right_d = right_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    if (state_q == CALC) begin
      tri_d   = tri_c;
      equ_d   = equ_c;
      iso_d   = iso_c;
      right_d = right_c;
      max_d   = z_q;
    end
    if (out_fire && tri_q && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      tri_q   <= 1'b0;
      equ_q   <= 1'b0;
      iso_q   <= 1'b0;
      right_q <= 1'b0;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      tri_q   <= tri_d;
      equ_q   <= equ_d;
      iso_q   <= iso_d;
      right_q <= right_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IS_TRI   = tri_q;
  assign IS_EQU   = equ_q;
  assign IS_ISO   = iso_q;
  assign IS_RIGHT = right_q;
  assign MAX_SIDE = max_q;
  assign TRI_CNT  = cnt_q;

endmodule

// File: tb/tb_triangle_classifier.sv
// Bench for triangle_classifier: behavioural model + per-cycle compare on a default
// instance, directed literal checks, and a CNT_W=2 instance for saturation/throughput.
module tb_triangle_classifier;

  localparam int W = 8;
`ifdef TRIANGLE_RIGHT_EN
  localparam int RIGHT_EXP = 1;
`else
  localparam int RIGHT_EXP = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, c, max_side;
  logic         is_tri, is_equ, is_iso, is_right;
  logic [15:0]  tri_cnt;

  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [W-1:0] a1, b1, c1, max_side1;
  logic         is_tri1, is_equ1, is_iso1, is_right1;
  logic [1:0]   tri_cnt1;

  triangle_classifier #(.WIDTH(W), .CNT_W(16)) dut (
    .CLK(clk), .RST_X(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .C(c), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .IS_TRI(is_tri), .IS_EQU(is_equ), .IS_ISO(is_iso), .IS_RIGHT(is_right),
    .MAX_SIDE(max_side), .TRI_CNT(tri_cnt));

  triangle_classifier #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .CLK(clk), .RST_X(rst_n), .IN_VALID(in_valid1), .IN_READY(in_ready1),
    .A(a1), .B(b1), .C(c1), .OUT_VALID(out_valid1), .OUT_READY(out_ready1),
    .IS_TRI(is_tri1), .IS_EQU(is_equ1), .IS_ISO(is_iso1), .IS_RIGHT(is_right1),
    .MAX_SIDE(max_side1), .TRI_CNT(tri_cnt1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int t; int e; int i; int r; int m;
  } res_t;

  function automatic res_t model(input int sa, input int sb, input int sc);
    res_t res;
    int s0, s1, s2, tmp;
    s0 = sa; s1 = sb; s2 = sc;
    if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end
    if (s1 > s2) begin tmp = s1; s1 = s2; s2 = tmp; end
    if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end
    res.t = (s0 + s1 > s2) ? 1 : 0;
    res.e = (res.t == 1 && s0 == s2) ? 1 : 0;
    res.i = (res.t == 1 && (s0 == s1 || s1 == s2)) ? 1 : 0;
    res.r = (RIGHT_EXP == 1 && res.t == 1 && s0*s0 + s1*s1 == s2*s2) ? 1 : 0;
    res.m = s2;
    return res;
  endfunction

  res_t exp_q[$];
  bit   busy    = 1'b0;
  int   exp_cnt = 0;

  // Per-cycle compare of the main instance against the model
  always @(negedge clk) begin
    res_t r;
    if (rst_n) begin
      chk("in_ready", in_ready, !busy);
      chk("tri_cnt", tri_cnt, exp_cnt);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
        else begin
          r = exp_q[0];
          chk("is_tri", is_tri, r.t);
          chk("is_equ", is_equ, r.e);
          chk("is_iso", is_iso, r.i);
          chk("is_right", is_right, r.r);
          chk("max_side", max_side, r.m);
          if (out_ready) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
            if (r.t == 1 && exp_cnt < 65535) exp_cnt++;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    busy = 1'b0;
    exp_cnt = 0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input int sa, input int sb, input int sc, output int acc);
    int n;
    @(posedge clk); #1;
    a = W'(sa); b = W'(sb); c = W'(sc);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    acc = -100;
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc = cyc;
      in_valid = 1'b0;
      exp_q.push_back(model(sa, sb, sc));
      busy = 1'b1;
    end
  endtask

  task automatic wait_out(input int acc, input bit lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    if (!out_valid) chk("out_timeout", out_valid, 1);
    else if (lat) chk("latency", cyc - acc, 4);
  endtask

  initial begin
    int acc;
    int accs[$];
    int cnts[$];
    int hs, n;
    bit pend;
    int exp_seq[5];

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; c = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; c1 = '0; out_ready1 = 1'b1;

    // Reset values
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_is_tri", is_tri, 0);
    chk("rst_is_equ", is_equ, 0);
    chk("rst_is_iso", is_iso, 0);
    chk("rst_is_right", is_right, 0);
    chk("rst_max_side", max_side, 0);
    chk("rst_tri_cnt", tri_cnt, 0);
    chk("rst_sat_cnt", tri_cnt1, 0);
    do_reset();

    // 3-4-5 triangle
    send(5, 3, 4, acc);
    wait_out(acc, 1'b1);
    chk("345_tri", is_tri, 1);
    chk("345_right", is_right, RIGHT_EXP);
    chk("345_iso", is_iso, 0);
    chk("345_equ", is_equ, 0);
    chk("345_max", max_side, 5);
    @(negedge clk);
    chk("345_cnt", tri_cnt, 1);

    // Overflow-safe sum, degenerate, zero side
    do_reset();
    send(255, 255, 255, acc);
    wait_out(acc, 1'b1);
    chk("255_tri", is_tri, 1);
    chk("255_equ", is_equ, 1);
    chk("255_iso", is_iso, 1);
    chk("255_max", max_side, 255);
    send(1, 2, 3, acc);
    wait_out(acc, 1'b1);
    chk("123_tri", is_tri, 0);
    chk("123_iso", is_iso, 0);
    chk("123_right", is_right, 0);
    chk("123_max", max_side, 3);
    send(0, 7, 7, acc);
    wait_out(acc, 1'b1);
    chk("077_tri", is_tri, 0);
    chk("077_iso", is_iso, 0);
    chk("077_equ", is_equ, 0);
    chk("077_max", max_side, 7);
    @(negedge clk);
    chk("seq_cnt", tri_cnt, 1);

    // Backpressure with a competing input that must be ignored
    out_ready = 1'b0;
    send(7, 7, 3, acc);
    wait_out(acc, 1'b1);
    a = 8'd9; b = 8'd9; c = 8'd9; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_iso", is_iso, 1);
      chk("bp_max", max_side, 7);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_cnt", tri_cnt, 1);
      @(negedge clk);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_cnt_after", tri_cnt, 2);
    chk("bp_out_after", out_valid, 0);
    repeat (8) begin
      @(negedge clk);
      chk("bp_no_extra", out_valid, 0);
    end

    // Reset during SORT2
    send(4, 5, 6, acc);
    @(posedge clk); #2;
    chk("mid_in_ready", in_ready, 0);
    chk("mid_cnt_before", tri_cnt, 2);
    rst_n = 1'b0;
    exp_q.delete();
    busy = 1'b0;
    exp_cnt = 0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready_rst", in_ready, 1);
    chk("mid_cnt_rst", tri_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(4, 5, 6, acc);
    wait_out(acc, 1'b1);
    chk("456_tri", is_tri, 1);
    chk("456_max", max_side, 6);

    // Saturation and initiation interval on the CNT_W=2 instance
    @(posedge clk); #1;
    a1 = 8'd3; b1 = 8'd3; c1 = 8'd3; in_valid1 = 1'b1;
    hs = 0; n = 0; pend = 1'b0;
    while (cnts.size() < 5 && n < 100) begin
      @(negedge clk); n++;
      if (pend) begin cnts.push_back(int'(tri_cnt1)); pend = 1'b0; end
      chk("sat_cnt_track", tri_cnt1, (hs < 3) ? hs : 3);
      if (in_ready1 && in_valid1) accs.push_back(cyc + 1);
      if (out_valid1 && out_ready1) begin
        chk("sat_tri", is_tri1, 1);
        hs++;
        pend = 1'b1;
      end
      if (accs.size() >= 5 && in_valid1) begin
        @(posedge clk); #1 in_valid1 = 1'b0;
      end
    end
    chk("sat_results", cnts.size(), 5);
    chk("sat_accepts", accs.size(), 5);
    exp_seq = '{1, 2, 3, 3, 3};
    if (cnts.size() == 5)
      for (int i = 0; i < 5; i++) chk("sat_seq", cnts[i], exp_seq[i]);
    if (accs.size() == 5)
      for (int i = 1; i < 5; i++) chk("sat_ii", accs[i] - accs[i-1], 6);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/triangle_classifier.md
# triangle_classifier

Sequential, parametrised triangle classifier. It accepts three unsigned side lengths over a valid/ready handshake and sorts them in place over three compare-and-swap cycles. It then registers a classification: valid triangle, equilateral, isosceles, optionally right-angled, plus the longest side. It sits behind any side-length producer in the geometry datapath and keeps a saturating count of valid triangles seen.

## Interface
Parameters:
- WIDTH, 8, side-length width in bits
- CNT_W, 16, width of the triangle counter

Ports:
- CLK  in  1  clock, rising edge
- RST_X  in  1  reset, asynchronous, active-low
- IN_VALID  in  1  A/B/C valid
- IN_READY  out  1  block can accept a new side set
- A, B, C  in  WIDTH each  unsigned side lengths
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts result
- IS_TRI  out  1  sides form a non-degenerate triangle
- IS_EQU  out  1  equilateral
- IS_ISO  out  1  at least two sides equal; includes equilateral
- IS_RIGHT  out  1  right-angled
- MAX_SIDE  out  WIDTH  longest side
- TRI_CNT  out  CNT_W  count of delivered results with IS_TRI=1

## Operation
- Internal registers: X, Y, Z (WIDTH each).
- FSM states: IDLE, SORT1, SORT2, SORT3, CALC, OUT.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY: X<=A, Y<=B, Z<=C; go to SORT1.
- SORT1: if X>Y, swap X and Y; go to SORT2.
- SORT2: if Y>Z, swap Y and Z; go to SORT3.
- SORT3: if X>Y, swap X and Y; go to CALC. After this step X<=Y<=Z.
- CALC:
  - SUM = X+Y, computed in WIDTH+1 bits (never overflows).
  - IS_TRI <= Z<SUM. A degenerate set (X+Y==Z) and any zero-length side both give IS_TRI=0.
  - IS_EQU <= IS_TRI & (X==Z).
  - IS_ISO <= IS_TRI & ((X==Y)|(Y==Z)).
  - IS_RIGHT <= IS_TRI & (X*X+Y*Y == Z*Z), compared in 2*WIDTH+1 bits.
  - MAX_SIDE <= Z.
  - Go to OUT.
- OUT:
  - OUT_VALID=1. All result outputs held stable until OUT_READY.
  - On OUT_VALID&OUT_READY: go to IDLE. If IS_TRI=1, TRI_CNT increments.
- Whenever IS_TRI=0, all of IS_EQU, IS_ISO and IS_RIGHT are 0.
- TRI_CNT saturates at all-ones; it never wraps.
- IN_READY=1 only in IDLE. A, B and C are ignored in every other state.
- OUT_VALID=1 only in OUT.
- Result outputs keep their last values outside OUT; the consumer samples them only when OUT_VALID=1.

## Timing
- Reset values:
  - State IDLE.
  - IN_READY=1.
  - OUT_VALID=0.
  - IS_TRI, IS_EQU, IS_ISO, IS_RIGHT = 0.
  - MAX_SIDE=0.
  - TRI_CNT=0.
  - X, Y, Z = 0.
- Latency: input accepted at edge n; OUT_VALID high from edge n+4.
- With OUT_READY held high:
  - Result handshake at edge n+5.
  - IN_READY high again after edge n+5.
  - Next accept at edge n+6, giving a minimum 6-cycle initiation interval.
- Backpressure: OUT may persist indefinitely; no input is accepted meanwhile.
- RST_X low in any state:
  - Immediate return to IDLE with all reset values, TRI_CNT included.
  - The in-flight side set is discarded and no result is emitted.
- OUT_READY outside OUT: ignored.
- IN_VALID outside IDLE: ignored; the producer must hold the data until IN_READY.

## Configuration
- Macro: TRIANGLE_RIGHT_EN.
- Defined:
  - Squaring and 2*WIDTH+1-bit comparison logic present.
  - IS_RIGHT computed as above.
- Undefined:
  - No multiplier logic.
  - IS_RIGHT tied to 0.
  - All other behaviour and timing identical.

## Test plan
- WIDTH=8, input (A,B,C)=(5,3,4), OUT_READY=1, macro defined:
  - OUT_VALID at accept edge+4.
  - IS_TRI=1, IS_RIGHT=1, IS_ISO=0, IS_EQU=0, MAX_SIDE=5.
  - TRI_CNT 0->1.
  - Same input with macro undefined: IS_RIGHT=0.
- Inputs (255,255,255), then (1,2,3), then (0,7,7):
  - (255,255,255): IS_TRI=IS_EQU=IS_ISO=1, MAX_SIDE=255. Checks that the sum does not overflow.
  - (1,2,3): all flags 0, MAX_SIDE=3.
  - (0,7,7): all flags 0, MAX_SIDE=7.
  - TRI_CNT ends at 1.
- Backpressure: input (7,7,3), OUT_READY=0 for 10 cycles after OUT_VALID:
  - Outputs stable with IS_ISO=1 throughout.
  - IN_READY=0 throughout; a new IN_VALID is ignored.
  - TRI_CNT increments only on the handshake edge.
- Reset mid-operation: accept (4,5,6), drive RST_X low during SORT2:
  - OUT_VALID stays 0 and IN_READY=1 immediately.
  - TRI_CNT=0.
  - After release, (4,5,6) yields IS_TRI=1.
- Saturation: CNT_W=2, five valid triangles (3,3,3) back-to-back:
  - TRI_CNT sequence 1,2,3,3,3.
  - Consecutive accepts exactly 6 edges apart.
